line_buffer_ctrl: RTL and testbench

Sequencer for the edge detector's line-buffer datapath (shift_8_multi_read chained into shift_32). Accepts a raster pixel stream over a valid/ready handshake and issues one write per accepted pixel, with a wrapping address, to the line buffers. Tracks column and row and flags when a full 3x3 window is available to the downstream edge kernel. Signals end of frame.

---
 rtl/line_buffer_ctrl_if.sv | 33 +++
 rtl/line_buffer_ctrl.sv | 150 +++++++++++++++
 tb/tb_line_buffer_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/line_buffer_ctrl_if.sv
// Pixel-stream, control and line-buffer write bundle for line_buffer_ctrl.
// The master side is the source/sequencer driving start, hold and pixels;
// the slave side is the controller itself.
interface line_buffer_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              start;
  logic              hold;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready;
  logic              lb_write_en;
  logic [ADDR_W-1:0] lb_addr;
  logic [DATA_W-1:0] lb_wr_data;
  logic              win_valid;
  logic [ADDR_W-1:0] col;
  logic [9:0]        row;
  logic              busy;
  logic              frame_done;

  modport master (
    output start, hold, pix_valid, pix_data,
    input  pix_ready, lb_write_en, lb_addr, lb_wr_data, win_valid,
    input  col, row, busy, frame_done
  );

  modport slave (
    input  start, hold, pix_valid, pix_data,
    output pix_ready, lb_write_en, lb_addr, lb_wr_data, win_valid,
    output col, row, busy, frame_done
  );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Line-buffer sequencer for the edge detector. Accepts a raster pixel stream,
// issues one registered write per accepted pixel at a wrapping column address,
// tracks row/column, flags complete 3x3 windows and pulses end of frame.
module line_buffer_ctrl #(
  parameter int LINE_WIDTH  = 40,
  parameter int FRAME_LINES = 30,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32
) (
  input logic              clk,
  input logic              rst,
  line_buffer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_WIDTH - 1);
  localparam logic [9:0]        LAST_ROW = 10'(FRAME_LINES - 1);

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] next_col_r;
  logic [ADDR_W-1:0] next_col_s;
  logic [9:0]        next_row_r;
  logic [9:0]        next_row_s;
  logic              ready_s;
  logic              accept_s;
  logic              line_end_s;
  logic              fill_end_s;
  logic              frame_end_s;

  logic              write_en_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic              win_valid_r;
  logic [ADDR_W-1:0] col_r;
  logic [9:0]        row_r;
  logic              busy_r;
  logic              frame_done_r;

  // Ready depends only on state and back-pressure, never on pix_valid.
  always_comb begin
    ready_s     = ((state_r == FILL) || (state_r == RUN)) && !bus.hold;
    accept_s    = ready_s && bus.pix_valid;
    line_end_s  = (next_col_r == LAST_COL);
    fill_end_s  = line_end_s && (next_row_r == 10'd1);
    frame_end_s = line_end_s && (next_row_r == LAST_ROW);
  end

  // Position of the next pixel to accept: cleared on a start from idle,
  // otherwise advanced per accept with column wrap carrying into row.
  always_comb begin
    next_col_s = next_col_r;
    next_row_s = next_row_r;
    if ((state_r == IDLE) && bus.start) begin
      next_col_s = {ADDR_W{1'b0}};
      next_row_s = 10'd0;
    end else if (accept_s) begin
      if (line_end_s) begin
        next_col_s = {ADDR_W{1'b0}};
        next_row_s = next_row_r + 10'd1;
      end else begin
        next_col_s = next_col_r + ADDR_W'(1);
        next_row_s = next_row_r;
      end
    end else begin
      next_col_s = next_col_r;
      next_row_s = next_row_r;
    end
  end

  // Frame sequencing: FILL until two lines are stored, RUN until the last
  // pixel, then a single DONE cycle. Start is honoured only from IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_s = FILL;
        else           state_s = IDLE;
      end
      FILL: begin
        if (accept_s && fill_end_s) state_s = RUN;
        else                        state_s = FILL;
      end
      RUN: begin
        if (accept_s && frame_end_s) state_s = DONE;
        else                         state_s = RUN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State and position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      next_col_r <= {ADDR_W{1'b0}};
      next_row_r <= 10'd0;
    end else begin
      state_r    <= state_s;
      next_col_r <= next_col_s;
      next_row_r <= next_row_s;
    end
  end

  // Registered write port: one strobe per accept, address/data/position held
  // between writes; window flag and frame-done aligned with the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_en_r   <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      wr_data_r    <= {DATA_W{1'b0}};
      win_valid_r  <= 1'b0;
      col_r        <= {ADDR_W{1'b0}};
      row_r        <= 10'd0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      write_en_r   <= accept_s;
      busy_r       <= (state_s != IDLE);
      frame_done_r <= (state_s == DONE);
      if (accept_s) begin
        addr_r      <= next_col_r;
        col_r       <= next_col_r;
        row_r       <= next_row_r;
        wr_data_r   <= bus.pix_data;
        win_valid_r <= (next_row_r >= 10'd2) && (next_col_r >= ADDR_W'(2));
      end else begin
        win_valid_r <= 1'b0;
      end
    end
  end

  assign bus.pix_ready   = ready_s;
  assign bus.lb_write_en = write_en_r;
  assign bus.lb_addr     = addr_r;
  assign bus.lb_wr_data  = wr_data_r;
  assign bus.win_valid   = win_valid_r;
  assign bus.col         = col_r;
  assign bus.row         = row_r;
  assign bus.busy        = busy_r;
  assign bus.frame_done  = frame_done_r;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl with a 4x3 frame. Expected behaviour comes from a
// pixel-index model: the n-th accepted pixel of a frame sits at column n%W,
// row n/W, and the frame ends at n = W*H-1.
module tb_line_buffer_ctrl;
  localparam int LW = 4;
  localparam int FL = 3;
  localparam int AW = 7;
  localparam int DW = 32;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  line_buffer_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  line_buffer_ctrl #(
    .LINE_WIDTH (LW),
    .FRAME_LINES(FL),
    .ADDR_W     (AW),
    .DATA_W     (DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 accepting, 2 done cycle; n = accepts this frame.
  int          m_phase;
  int          m_n;
  logic        e_we;
  logic [31:0] e_addr;
  logic [31:0] e_data;
  logic [31:0] e_row;
  logic        e_win;
  logic        e_fd;
  logic        e_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_n = 0;
    e_we = 1'b0; e_addr = 32'd0; e_data = 32'd0; e_row = 32'd0;
    e_win = 1'b0; e_fd = 1'b0; e_busy = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".we"},    32'(bus.lb_write_en), 32'(e_we));
    chk({tag, ".addr"},  32'(bus.lb_addr),     e_addr);
    chk({tag, ".col"},   32'(bus.col),         e_addr);
    chk({tag, ".row"},   32'(bus.row),         e_row);
    chk({tag, ".data"},  bus.lb_wr_data,       e_data);
    chk({tag, ".win"},   32'(bus.win_valid),   32'(e_win));
    chk({tag, ".fdone"}, 32'(bus.frame_done),  32'(e_fd));
    chk({tag, ".busy"},  32'(bus.busy),        32'(e_busy));
  endtask

  // One clock: entered and left at a falling edge.
  task automatic step(input logic st, input logic hd, input logic vl, input logic [31:0] dt);
    logic exp_ready;
    logic acc;
    bus.start = st; bus.hold = hd; bus.pix_valid = vl; bus.pix_data = dt;
    #1;
    exp_ready = (m_phase == 1) && !hd;
    chk("pix_ready", 32'(bus.pix_ready), 32'(exp_ready));
    acc = vl && exp_ready;
    @(posedge clk);
    #1;
    e_we = 1'b0; e_win = 1'b0; e_fd = 1'b0;
    case (m_phase)
      0: if (st) begin m_phase = 1; m_n = 0; end
      1: if (acc) begin
        e_we   = 1'b1;
        e_addr = 32'(m_n % LW);
        e_row  = 32'(m_n / LW);
        e_data = dt;
        e_win  = (e_row >= 32'd2) && (e_addr >= 32'd2);
        if (m_n == LW * FL - 1) begin
          m_phase = 2;
          e_fd    = 1'b1;
        end
        m_n++;
      end
      default: m_phase = 0;
    endcase
    e_busy = (m_phase != 0);
    check_outputs("cyc");
    @(negedge clk);
  endtask

  // Reset asserted in the middle of the low phase, released on a falling edge.
  task automatic reset_mid();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("rst");
    chk("rst.ready", 32'(bus.pix_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Whole frame under random or alternating pix_valid, bounded in cycles.
  task automatic random_frame(input bit alt, input int budget);
    int   k;
    logic v;
    logic h;
    k = 0;
    step(1'b1, 1'b0, 1'b0, 32'd0);
    while (m_phase != 0 && k < budget) begin
      v = alt ? ~k[0] : 1'($urandom_range(0, 1));
      h = alt ? 1'b0 : ($urandom_range(0, 3) == 0);
      step(1'b0, h, v, $urandom);
      k++;
    end
    chk("frame_end_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.hold = 1'b0; bus.pix_valid = 1'b0; bus.pix_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_outputs("post_rst");

    // Reset mid-clock with a pending pixel.
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h55);
    bus.pix_valid = 1'b1;
    reset_mid();

    // Start then 12 back-to-back pixels, then the return to idle.
    step(1'b1, 1'b0, 1'b1, 32'd0);
    for (int i = 1; i <= 12; i++) step(1'b0, 1'b0, 1'b1, 32'(i));
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);

    // Back-pressure after pixel 5, start in RUN and in DONE ignored.
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b1, 32'(i + 100));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 32'd106);
    step(1'b0, 1'b0, 1'b1, 32'd106);
    chk("p6.addr", 32'(bus.lb_addr), 32'd1);
    chk("p6.row",  32'(bus.row),     32'd1);
    for (int i = 7; i <= 12; i++) step((i == 10), 1'b0, 1'b1, 32'(i + 100));
    chk("p12.fdone", 32'(bus.frame_done), 32'd1);
    step(1'b1, 1'b0, 1'b1, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'hA0);
    step(1'b0, 1'b0, 1'b1, 32'hA1);
    chk("restart.addr", 32'(bus.lb_addr), 32'd0);
    chk("restart.row",  32'(bus.row),     32'd0);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 1'b1, $urandom);
    step(1'b0, 1'b0, 1'b0, 32'd0);

    // Sparse source with pix_valid alternating.
    random_frame(1'b1, 100);

    // Reset mid-frame at pixel 7, then a fresh random frame.
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 1; i <= 7; i++) step(1'b0, 1'b0, 1'b1, 32'(i + 200));
    reset_mid();
    random_frame(1'b0, 200);
    random_frame(1'b0, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
